// File: rtl/pma_lookup_arbiter.sv
// pma_lookup_arbiter: round-robin shared PMA lookup engine that scans the non-idempotent,
// execute and cached rule tables one rule per cycle through a single range comparator.
`default_nettype none

module pma_lookup_arbiter #(
  parameter int unsigned       NrReq                 = 3,
  // Rule tables hold up to 16 entries each; only the first Nr*Rules entries are used.
  parameter int unsigned       NrNonIdempotentRules  = 0,
  parameter logic [15:0][63:0] NonIdempotentAddrBase = '0,
  parameter logic [15:0][63:0] NonIdempotentLength   = '0,
  parameter int unsigned       NrExecuteRegionRules  = 0,
  parameter logic [15:0][63:0] ExecuteRegionAddrBase = '0,
  parameter logic [15:0][63:0] ExecuteRegionLength   = '0,
  parameter int unsigned       NrCachedRegionRules   = 0,
  parameter logic [15:0][63:0] CachedRegionAddrBase  = '0,
  parameter logic [15:0][63:0] CachedRegionLength    = '0
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NrReq-1:0]       req_valid_i,
  output logic [NrReq-1:0]       req_ready_o,
  input  logic [NrReq-1:0][63:0] req_addr_i,
  output logic [NrReq-1:0]       resp_valid_o,
  input  logic [NrReq-1:0]       resp_ready_i,
  output logic                   resp_nonidem_o,
  output logic                   resp_exec_o,
  output logic                   resp_cached_o,
  output logic                   busy_o
);

  localparam int unsigned     IdxW     = (NrReq > 1) ? $clog2(NrReq) : 1;
  localparam logic [IdxW-1:0] LastInit = IdxW'(NrReq - 1);
  localparam bit              HasNi    = (NrNonIdempotentRules != 0);
  localparam bit              HasEx    = (NrExecuteRegionRules != 0);
  localparam bit              HasCa    = (NrCachedRegionRules != 0);

  typedef enum logic [2:0] {IDLE, SCAN_NI, SCAN_EX, SCAN_CA, RESP} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] last_q, last_d, winner_q, winner_d;
  logic [63:0]     addr_q, addr_d;
  logic [3:0]      k_q, k_d;
  logic            ni_q, ni_d, ex_q, ex_d, ca_q, ca_d;

  logic            grant_found;
  logic [IdxW-1:0] grant_idx;
  int unsigned     arb_cand;
  logic [63:0]     base_k, len_k;
  logic [3:0]      last_k;
  logic            hit;

  // Next table to visit after the given one; empty tables are skipped entirely.
  function automatic state_e next_table(input state_e s);
    state_e n;
    n = RESP;
    if (s == IDLE && HasNi) n = SCAN_NI;
    else if ((s == IDLE || s == SCAN_NI) && HasEx) n = SCAN_EX;
    else if (s != SCAN_CA && HasCa) n = SCAN_CA;
    return n;
  endfunction

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    arb_cand    = 0;
    for (int unsigned i = 0; i < NrReq; i++) begin
      arb_cand = (32'(last_q) + 32'd1 + i) % NrReq;
      if (!grant_found && req_valid_i[IdxW'(arb_cand)]) begin
        grant_found = 1'b1;
        grant_idx   = IdxW'(arb_cand);
      end
    end
  end

  always_comb begin
    base_k = '0;
    len_k  = '0;
    last_k = '0;
    case (state_q)
      SCAN_NI: begin
        base_k = NonIdempotentAddrBase[k_q];
        len_k  = NonIdempotentLength[k_q];
        last_k = 4'(NrNonIdempotentRules - 1);
      end
      SCAN_EX: begin
        base_k = ExecuteRegionAddrBase[k_q];
        len_k  = ExecuteRegionLength[k_q];
        last_k = 4'(NrExecuteRegionRules - 1);
      end
      SCAN_CA: begin
        base_k = CachedRegionAddrBase[k_q];
        len_k  = CachedRegionLength[k_q];
        last_k = 4'(NrCachedRegionRules - 1);
      end
      default: ;
    endcase
  end

  // 65-bit end address so regions reaching the top of the address space do not wrap.
  assign hit = (addr_q >= base_k) && ({1'b0, addr_q} < ({1'b0, base_k} + {1'b0, len_k}));

  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    winner_d     = winner_q;
    addr_d       = addr_q;
    k_d          = k_q;
    ni_d         = ni_q;
    ex_d         = ex_q;
    ca_d         = ca_q;
    req_ready_o  = '0;
    resp_valid_o = '0;
    case (state_q)
      IDLE: begin
        if (grant_found && rst_ni) begin
          req_ready_o[grant_idx] = 1'b1;
          addr_d   = req_addr_i[grant_idx];
          winner_d = grant_idx;
          last_d   = grant_idx;
          ni_d     = 1'b0;
          ex_d     = 1'b0;
          ca_d     = 1'b0;
          k_d      = '0;
          state_d  = next_table(IDLE);
        end
      end
      SCAN_NI, SCAN_EX, SCAN_CA: begin
        if (hit || k_q == last_k) begin
          k_d     = '0;
          state_d = next_table(state_q);
          case (state_q)
            SCAN_NI: ni_d = hit;
            SCAN_EX: ex_d = hit;
            default: ca_d = hit;
          endcase
        end else begin
          k_d = k_q + 4'd1;
        end
      end
      RESP: begin
        resp_valid_o[winner_q] = 1'b1;
        if (resp_ready_i[winner_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o         = (state_q != IDLE);
  assign resp_nonidem_o = (state_q == RESP) && ni_q;
  assign resp_exec_o    = (state_q == RESP) && ex_q;
  assign resp_cached_o  = (state_q == RESP) && ca_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      last_q   <= LastInit;
      winner_q <= '0;
      addr_q   <= '0;
      k_q      <= '0;
      ni_q     <= 1'b0;
      ex_q     <= 1'b0;
      ca_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      winner_q <= winner_d;
      addr_q   <= addr_d;
      k_q      <= k_d;
      ni_q     <= ni_d;
      ex_q     <= ex_d;
      ca_q     <= ca_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pma_lookup_arbiter.sv
// Testbench for pma_lookup_arbiter: three configurations (main tables, top-of-memory cached
// rule, all tables empty) share one stimulus bus; table vectors plus directed sequences.
`default_nettype none

module tb_pma_lookup_arbiter;

  localparam logic [15:0][63:0] NI_BASE_A = '0;
  localparam logic [15:0][63:0] NI_LEN_A  = {{15{64'h0}}, 64'h8000_0000};
  localparam logic [15:0][63:0] EX_BASE_A = {{14{64'h0}}, 64'h8000_0000, 64'h1000};
  localparam logic [15:0][63:0] EX_LEN_A  = {{14{64'h0}}, 64'h4000_0000, 64'h1000};
  localparam logic [15:0][63:0] CA_BASE_A = {{15{64'h0}}, 64'h8000_0000};
  localparam logic [15:0][63:0] CA_LEN_A  = {{15{64'h0}}, 64'h4000_0000};
  localparam logic [15:0][63:0] CA_BASE_B = {{15{64'h0}}, 64'hFFFF_FFFF_FFFF_F000};
  localparam logic [15:0][63:0] CA_LEN_B  = {{15{64'h0}}, 64'h2000};

  logic            clk = 1'b0;
  logic            rst_n;
  logic [2:0]      req_valid;
  logic [2:0][63:0] req_addr;
  logic [2:0]      resp_ready;

  logic [2:0] rdy [3];
  logic [2:0] rv  [3];
  logic       ni  [3];
  logic       ex  [3];
  logic       ca  [3];
  logic       busy[3];

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  pma_lookup_arbiter #(
    .NrReq(3),
    .NrNonIdempotentRules(1), .NonIdempotentAddrBase(NI_BASE_A), .NonIdempotentLength(NI_LEN_A),
    .NrExecuteRegionRules(2), .ExecuteRegionAddrBase(EX_BASE_A), .ExecuteRegionLength(EX_LEN_A),
    .NrCachedRegionRules(1),  .CachedRegionAddrBase(CA_BASE_A),  .CachedRegionLength(CA_LEN_A)
  ) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_ready_o(rdy[0]),
    .req_addr_i(req_addr), .resp_valid_o(rv[0]), .resp_ready_i(resp_ready),
    .resp_nonidem_o(ni[0]), .resp_exec_o(ex[0]), .resp_cached_o(ca[0]), .busy_o(busy[0])
  );

  pma_lookup_arbiter #(
    .NrReq(3),
    .NrCachedRegionRules(1), .CachedRegionAddrBase(CA_BASE_B), .CachedRegionLength(CA_LEN_B)
  ) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_ready_o(rdy[1]),
    .req_addr_i(req_addr), .resp_valid_o(rv[1]), .resp_ready_i(resp_ready),
    .resp_nonidem_o(ni[1]), .resp_exec_o(ex[1]), .resp_cached_o(ca[1]), .busy_o(busy[1])
  );

  pma_lookup_arbiter #(
    .NrReq(3)
  ) dut_c (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_ready_o(rdy[2]),
    .req_addr_i(req_addr), .resp_valid_o(rv[2]), .resp_ready_i(resp_ready),
    .resp_nonidem_o(ni[2]), .resp_exec_o(ex[2]), .resp_cached_o(ca[2]), .busy_o(busy[2])
  );

  typedef struct {
    int          sel;
    int          req;
    logic [63:0] addr;
    int          lat;
    logic        e_ni;
    logic        e_ex;
    logic        e_ca;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy[0] | busy[1] | busy[2]) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("idle_timeout", 1, 0);
  endtask

  task automatic lookup(input vec_t v);
    int n;
    wait_idle();
    resp_ready       = 3'b111;
    req_addr[v.req]  = v.addr;
    req_valid        = 3'b001 << v.req;
    #1;
    chk("grant", rdy[v.sel], 3'b001 << v.req);
    @(negedge clk);
    req_valid       = '0;
    req_addr[v.req] = ~v.addr;
    n = 1;
    while (rv[v.sel] == 3'b000 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("latency", n, v.lat);
    chk("resp_valid", rv[v.sel], 3'b001 << v.req);
    chk("nonidem", ni[v.sel], v.e_ni);
    chk("exec", ex[v.sel], v.e_ex);
    chk("cached", ca[v.sel], v.e_ca);
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_busy"}, busy[0], 0);
    chk({tag, "_rdy"}, rdy[0], 0);
    chk({tag, "_rv"}, rv[0], 0);
    chk({tag, "_bits"}, {ni[0], ex[0], ca[0]}, 0);
  endtask

  initial begin
    int          grants[$];
    int          n;
    logic [2:0]  held;

    vecs[0]  = '{0, 0, 64'h8000_0010,          5, 1'b0, 1'b1, 1'b1};
    vecs[1]  = '{0, 1, 64'h1000_0000,          5, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{0, 2, 64'hBFFF_FFFF,          5, 1'b0, 1'b1, 1'b1};
    vecs[3]  = '{0, 0, 64'hC000_0000,          5, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{0, 1, 64'h1000,               4, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{0, 2, 64'h1FFF,               4, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{0, 0, 64'h2000,               5, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{0, 1, 64'h7FFF_FFFF,          5, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{0, 2, 64'h8000_0000,          5, 1'b0, 1'b1, 1'b1};
    vecs[9]  = '{1, 0, 64'hFFFF_FFFF_FFFF_FFF8, 2, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{1, 1, 64'h0,                  2, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1, 2, 64'hFFFF_FFFF_FFFF_EFFF, 2, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{2, 0, 64'h1234,               1, 1'b0, 1'b0, 1'b0};

    rst_n      = 1'b0;
    req_valid  = '0;
    req_addr   = '0;
    resp_ready = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_quiet("reset");

    foreach (vecs[i]) lookup(vecs[i]);

    // Round-robin fairness from a fresh pointer with every requester asking.
    wait_idle();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n      = 1'b1;
    req_addr   = {3{64'h8000_0010}};
    resp_ready = 3'b111;
    req_valid  = 3'b111;
    n = 0;
    while (grants.size() < 6 && n < 80) begin
      #1;
      for (int j = 0; j < 3; j++) if (rdy[0][j]) grants.push_back(j);
      @(negedge clk);
      n++;
    end
    chk("fair_count", grants.size(), 6);
    for (int j = 0; j < grants.size(); j++) chk("fair_order", grants[j], j % 3);

    // Stalled response: outputs hold, no new grant.
    resp_ready = 3'b000;
    n = 0;
    while (rv[0] == 3'b000 && n < 20) begin
      @(negedge clk);
      n++;
    end
    held = rv[0];
    chk("stall_onehot", $countones(held), 1);
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      chk("stall_rv", rv[0], held);
      chk("stall_bits", {ni[0], ex[0], ca[0]}, 3'b011);
      chk("stall_rdy", rdy[0], 0);
    end
    req_valid  = '0;
    resp_ready = 3'b111;
    @(negedge clk);
    wait_idle();

    // Reset during SCAN_EX after requester 1 was granted.
    req_addr[1] = 64'h8000_0010;
    req_valid   = 3'b010;
    #1;
    chk("rst_grant1", rdy[0], 3'b010);
    @(negedge clk);
    req_valid = '0;
    chk("rst_busy_ni", busy[0], 1);
    @(negedge clk);
    chk("rst_busy_ex", busy[0], 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_quiet("midrst");
    req_valid = 3'b111;
    #1;
    chk("rst_ptr_grant", rdy[0], 3'b001);
    @(negedge clk);
    req_valid = '0;
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
